alu_scheduler: RTL

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_pkg.sv | 17 +
 rtl/rr_arb2.sv | 19 +
 rtl/alu_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU scheduler.
//   opsel_t   : 3-bit ALU operation select
//   state_t   : scheduler FSM states
//   WIDTH_DEF : default operand/result width
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  typedef logic [2:0] opsel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   req        : request vector (index 0, 1)
//   last_grant : index of the requester granted most recently
//   gnt        : one-hot grant (all zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    // On a tie the requester that did not win last time gets the slot.
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external combinational ALU between two requesters.
// One operation at a time: IDLE accepts, EXEC drives the ALU for a single
// cycle and captures its result, RESP holds the result until consumed.
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid/ready/opsel/mode/a/b : per-requester request channel
//   alu_opsel/mode/a/b          : operands to the shared ALU (zero unless EXEC)
//   alu_y, alu_cout             : ALU result
//   rsp_valid/ready/id/y/cout   : response channel
//   busy                        : FSM not in IDLE
//   ops_done                    : completed response count (wraps)
//
// state | meaning
// IDLE  | waiting for a request, req_ready driven from the arbiter
// EXEC  | issue registers drive the ALU, result captured at end of cycle
// RESP  | response presented until rsp_ready
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][2:0]       req_opsel,
  input  logic [1:0]            req_mode,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  output logic [2:0]            alu_opsel,
  output logic                  alu_mode,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_y,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_y,
  output logic                  rsp_cout,
  output logic                  busy,
  output logic [15:0]           ops_done
);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  opsel_t           iss_opsel_q, iss_opsel_d;
  logic             iss_mode_q, iss_mode_d;
  logic [WIDTH-1:0] iss_a_q, iss_a_d;
  logic [WIDTH-1:0] iss_b_q, iss_b_d;
  logic             iss_id_q, iss_id_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_id_q, rsp_id_d;
  logic [15:0]      ops_done_q, ops_done_d;

  logic [1:0] gnt;
  logic       acc_id;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  // gnt is one-hot when non-zero, so bit 1 is the granted index.
  assign acc_id = gnt[1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    iss_opsel_d  = iss_opsel_q;
    iss_mode_d   = iss_mode_q;
    iss_a_d      = iss_a_q;
    iss_b_d      = iss_b_q;
    iss_id_d     = iss_id_q;
    rsp_y_d      = rsp_y_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_id_d     = rsp_id_q;
    ops_done_d   = ops_done_q;
    req_ready    = 2'b00;
    alu_opsel    = '0;
    alu_mode     = 1'b0;
    alu_a        = '0;
    alu_b        = '0;

    case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        // A grant only exists for a valid requester, so any grant is a transfer.
        if (gnt != 2'b00) begin
          iss_opsel_d  = req_opsel[acc_id];
          iss_mode_d   = req_mode[acc_id];
          iss_a_d      = req_a[acc_id];
          iss_b_d      = req_b[acc_id];
          iss_id_d     = acc_id;
          last_grant_d = acc_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_opsel  = iss_opsel_q;
        alu_mode   = iss_mode_q;
        alu_a      = iss_a_q;
        alu_b      = iss_b_q;
        rsp_y_d    = alu_y;
        rsp_cout_d = alu_cout;
        rsp_id_d   = iss_id_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          ops_done_d = ops_done_q + 16'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      iss_opsel_q  <= '0;
      iss_mode_q   <= 1'b0;
      iss_a_q      <= '0;
      iss_b_q      <= '0;
      iss_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      iss_opsel_q  <= iss_opsel_d;
      iss_mode_q   <= iss_mode_d;
      iss_a_q      <= iss_a_d;
      iss_b_q      <= iss_b_d;
      iss_id_q     <= iss_id_d;
      rsp_y_q      <= rsp_y_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_id_q     <= rsp_id_d;
      ops_done_q   <= ops_done_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_cout  = rsp_cout_q;
  assign ops_done  = ops_done_q;

endmodule
